// File: rtl/seg_decode_capture.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus.
// Each {seg_n, an_n} pattern must hold for a stability window before it commits to that digit.
module seg_decode_capture #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     blank,
    output logic                  update,
    output logic                  err
);

    localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_an;
    logic [CW-1:0]     r_cnt;
    logic              r_update;
    logic              r_err;

    logic              w_same;
    logic              w_commit;
    logic              w_legal;
    logic              w_blank_code;
    logic [3:0]        w_nib;
    logic [DIGITS-1:0] w_sel;
    logic              w_any;
    logic              w_multi;
    logic              w_wr_legal;
    logic              w_wr_blank;
    logic              w_err_set;

    assign w_same   = (seg_n == r_seg) && (an_n == r_an);
    // The commit fires only on the edge that brings the counter up to saturation.
    assign w_commit = w_same && (r_cnt == CNT_PRE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= '1;
            r_an  <= '1;
            r_cnt <= '0;
        end else begin
            r_seg <= seg_n;
            r_an  <= an_n;
            if (clear || !w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_legal      = 1'b1;
        w_blank_code = 1'b0;
        w_nib        = 4'h0;
        case (r_seg)
            7'b1000000: w_nib = 4'h0;
            7'b1111001: w_nib = 4'h1;
            7'b0100100: w_nib = 4'h2;
            7'b0110000: w_nib = 4'h3;
            7'b0011001: w_nib = 4'h4;
            7'b0010010: w_nib = 4'h5;
            7'b0000010: w_nib = 4'h6;
            7'b1111000: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0010000: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b0000011: w_nib = 4'hB;
            7'b1000110: w_nib = 4'hC;
            7'b0100001: w_nib = 4'hD;
            7'b0000110: w_nib = 4'hE;
            7'b0001110: w_nib = 4'hF;
            7'b1111111: begin
                w_legal      = 1'b0;
                w_blank_code = 1'b1;
            end
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_sel   = ~r_an;
    assign w_any   = |w_sel;
    // Clearing the lowest set bit leaves something only if two or more anodes are active.
    assign w_multi = |(w_sel & (w_sel - DIGITS'(1)));

    assign w_wr_legal = w_commit && w_any && !w_multi && w_legal;
    assign w_wr_blank = w_commit && w_any && !w_multi && w_blank_code;
    assign w_err_set  = w_commit && w_any && (w_multi || (!w_legal && !w_blank_code));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_update <= 1'b0;
            r_err    <= 1'b0;
        end else if (clear) begin
            r_update <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_update <= w_wr_legal || w_wr_blank;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign update = r_update;
    assign err    = r_err;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] r_val;
            logic       r_valid;
            logic       r_blank;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_val   <= 4'h0;
                    r_valid <= 1'b0;
                    r_blank <= 1'b0;
                end else if (clear) begin
                    r_val   <= 4'h0;
                    r_valid <= 1'b0;
                    r_blank <= 1'b0;
                end else if (w_sel[gi] && w_wr_legal) begin
                    r_val   <= w_nib;
                    r_valid <= 1'b1;
                    r_blank <= 1'b0;
                end else if (w_sel[gi] && w_wr_blank) begin
                    r_val   <= 4'h0;
                    r_valid <= 1'b0;
                    r_blank <= 1'b1;
                end
            end

            assign value[4*gi +: 4] = r_val;
            assign digit_valid[gi]  = r_valid;
            assign blank[gi]        = r_blank;
        end
    endgenerate

endmodule

// File: tb/tb_seg_decode_capture.sv
// Bench for seg_decode_capture: directed test-plan scenarios plus randomized holds,
// checked every cycle against a run-length based model of the display bus.
module tb_seg_decode_capture;

    localparam int D  = 8;
    localparam int SC = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic [6:0]     seg_n;
    logic [D-1:0]   an_n;
    logic [4*D-1:0] value;
    logic [D-1:0]   digit_valid;
    logic [D-1:0]   blank;
    logic           update;
    logic           err;

    seg_decode_capture #(.DIGITS(D), .STABLE_CYCLES(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .clear      (clear),
        .value      (value),
        .digit_valid(digit_valid),
        .blank      (blank),
        .update     (update),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_upd = 0;
    int n_txn = 0;

    logic [6:0] codes [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: run length of identical samples, plus the per-digit register image.
    logic [14:0]  m_prev;
    int           m_run;
    logic [3:0]   m_val [D];
    logic [D-1:0] m_valid;
    logic [D-1:0] m_blank;
    logic         m_upd;
    logic         m_err;

    task automatic model_reset();
        m_prev  = '1;
        m_run   = 0;
        for (int i = 0; i < D; i++) m_val[i] = 4'h0;
        m_valid = '0;
        m_blank = '0;
        m_upd   = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        logic [14:0] x;
        bit          same;
        bit          commit;
        int          lows;
        int          idx;
        int          code;
        x      = {seg_n, an_n};
        same   = (x == m_prev);
        commit = same && (m_run == SC - 1);
        m_run  = same ? ((m_run + 1 > SC) ? SC : m_run + 1) : 0;
        m_upd  = 1'b0;
        if (clear) begin
            for (int i = 0; i < D; i++) m_val[i] = 4'h0;
            m_valid = '0;
            m_blank = '0;
            m_err   = 1'b0;
            m_run   = 0;
        end else if (commit) begin
            lows = 0;
            idx  = 0;
            code = -1;
            for (int i = 0; i < D; i++) if (!an_n[i]) begin lows++; idx = i; end
            for (int c = 0; c < 16; c++) if (codes[c] == seg_n) code = c;
            if (lows == 1) begin
                if (code >= 0) begin
                    m_val[idx] = 4'(code); m_valid[idx] = 1'b1; m_blank[idx] = 1'b0; m_upd = 1'b1;
                end else if (seg_n == 7'h7F) begin
                    m_val[idx] = 4'h0; m_valid[idx] = 1'b0; m_blank[idx] = 1'b1; m_upd = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end else if (lows > 1) begin
                m_err = 1'b1;
            end
        end
        m_prev = x;
    endtask

    initial forever @(posedge rst) model_reset();
    initial forever @(posedge clk) begin
        if (rst) model_reset();
        else     model_step();
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    initial forever @(negedge clk) begin
        logic [4*D-1:0] exp_val;
        for (int i = 0; i < D; i++) exp_val[4*i +: 4] = m_val[i];
        chk("value", 64'(value), 64'(exp_val));
        chk("digit_valid", 64'(digit_valid), 64'(m_valid));
        chk("blank", 64'(blank), 64'(m_blank));
        chk("update", 64'(update), 64'(m_upd));
        chk("err", 64'(err), 64'(m_err));
        if (update === 1'b1) n_upd++;
    end

    // Called just after an active edge; drives a pattern for n edges, clear on the first.
    task automatic hold(input logic [6:0] s, input logic [D-1:0] a, input int n, input bit clr);
        n_txn++;
        $display("txn %0d seg=%b an=%h edges=%0d clr=%0b", n_txn, s, a, n, clr);
        seg_n = s;
        an_n  = a;
        clear = clr;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (n - 1) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int u0;
        logic [6:0]   s;
        logic [D-1:0] a;
        int           k;

        rst   = 1'b1;
        clear = 1'b0;
        seg_n = 7'h7F;
        an_n  = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset value", 64'(value), 64'h0);
        chk("reset valid", 64'(digit_valid), 64'h0);
        chk("reset err", 64'(err), 64'h0);

        hold(codes[7], 8'hDF, 5, 1'b0);
        chk("digit5=7", 64'(value[23:20]), 64'h7);
        chk("update after commit", 64'(update), 64'h1);

        // Async reset in the middle of a stability window.
        hold(codes[2], 8'hFE, 2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst value", 64'(value), 64'h0);
        chk("async rst valid", 64'(digit_valid), 64'h0);
        chk("async rst update", 64'(update), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        u0 = n_upd;
        hold(codes[2], 8'hFE, 5, 1'b0);
        chk("digit0=2", 64'(value[3:0]), 64'h2);
        chk("valid after 2", 64'(digit_valid), 64'h01);
        hold(codes[2], 8'hFE, 20, 1'b0);
        chk("single pulse", 64'(n_upd - u0), 64'd1);

        u0 = n_upd;
        hold(codes[9], 8'hFD, 4, 1'b0);
        hold(7'h7F, 8'hFF, 8, 1'b0);
        chk("glitch no update", 64'(n_upd - u0), 64'd0);
        chk("glitch value", 64'(value), 64'h2);

        u0 = n_upd;
        hold(codes[1],  8'h7F, 6, 1'b0);
        hold(codes[2],  8'hBF, 6, 1'b0);
        hold(codes[3],  8'hDF, 6, 1'b0);
        hold(codes[4],  8'hEF, 6, 1'b0);
        hold(codes[10], 8'hF7, 6, 1'b0);
        hold(codes[11], 8'hFB, 6, 1'b0);
        hold(codes[12], 8'hFD, 6, 1'b0);
        hold(codes[13], 8'hFE, 6, 1'b0);
        chk("scan value", 64'(value), 64'h1234ABCD);
        chk("scan valid", 64'(digit_valid), 64'hFF);
        chk("scan pulses", 64'(n_upd - u0), 64'd8);

        hold(7'b0111111, 8'hF7, 6, 1'b0);
        chk("illegal err", 64'(err), 64'h1);
        chk("illegal keeps digit3", 64'(value[15:12]), 64'hA);
        hold(7'h7F, 8'hFE, 6, 1'b0);
        chk("blank0", 64'(blank), 64'h01);
        chk("blank valid", 64'(digit_valid), 64'hFE);
        chk("blank value", 64'(value), 64'h1234ABC0);
        u0 = n_upd;
        hold(codes[5], 8'hFC, 6, 1'b0);
        chk("multi err", 64'(err), 64'h1);
        chk("multi no update", 64'(n_upd - u0), 64'd0);
        chk("multi value", 64'(value), 64'h1234ABC0);

        // Clear lands on the commit edge of a legal pattern.
        hold(codes[6], 8'hBF, 4, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear value", 64'(value), 64'h0);
        chk("clear valid", 64'(digit_valid), 64'h0);
        chk("clear blank", 64'(blank), 64'h0);
        chk("clear err", 64'(err), 64'h0);
        chk("clear update", 64'(update), 64'h0);
        hold(7'h7F, 8'hFF, 3, 1'b0);

        for (int t = 0; t < 300; t++) begin
            k = int'($urandom_range(0, 99));
            if (k < 60)      s = codes[$urandom_range(0, 15)];
            else if (k < 75) s = 7'h7F;
            else             s = 7'($urandom);
            k = int'($urandom_range(0, 99));
            if (k < 60)      a = ~(D'(1) << $urandom_range(0, D - 1));
            else if (k < 75) a = '1;
            else             a = D'($urandom);
            hold(s, a, int'($urandom_range(1, 8)), ($urandom_range(0, 19) == 0));
            if (t % 100 == 50) begin
                #2;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_decode_capture.md
# seg_decode_capture

Recovers hexadecimal digit values from a multiplexed, active-low seven-segment display bus, the inverse of the team's hex-to-segment encoder path. It samples segment and digit-select lines and requires each pattern to hold for a stability window. It then decodes the pattern back to a nibble and stores it per digit. It sits on the verification and self-test side of the display path (npc board-display loopback), presenting a register image of what the display is actually showing.

## Interface
Parameters:
- DIGITS, 8, number of display digits / anode lines (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required before commit (>=1)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- seg_n  input  7  segment lines, active-low, bit0=a … bit6=g
- an_n  input  DIGITS  digit select, active-low, one-hot-low expected
- clear  input  1  synchronous clear of captured state
- value  output  4*DIGITS  decoded nibbles, digit i at [4i+3:4i]
- digit_valid  output  DIGITS  digit i holds a legally decoded nibble
- blank  output  DIGITS  digit i last committed as all-segments-off
- update  output  1  one-cycle pulse on each legal or blank commit
- err  output  1  sticky: illegal pattern or multiple anodes committed

## Operation
- Legal codes, seg_n[6:0] to nibble:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011
  - C=1000110, D=0100001, E=0000110, F=0001110
- Blank code: 1111111. Every other pattern is illegal.
- Registers:
  - s_reg holds {seg_n, an_n} sampled every edge.
  - cnt is a counter of width clog2(STABLE_CYCLES+1).
- Each edge:
  - If inputs equal s_reg, cnt <= min(cnt+1, STABLE_CYCLES); otherwise cnt <= 0.
  - s_reg <= inputs.
- Commit: occurs on the edge where cnt transitions to STABLE_CYCLES. It happens once per stable run; a saturated cnt never re-commits. The decision uses the stable sample:
  - an_n all ones: no digit selected, ignore; no update, no err.
  - Exactly one an_n bit low (index i), legal code: value[i] <= nibble, digit_valid[i] <= 1, blank[i] <= 0, update pulses.
  - Exactly one low, blank code: value[i] <= 0, digit_valid[i] <= 0, blank[i] <= 1, update pulses.
  - Exactly one low, illegal code: err <= 1; digit i state unchanged; no update.
  - Two or more an_n bits low: err <= 1; no digit changes; no update.
- clear:
  - Zeros value, digit_valid, blank, err and cnt; does not touch s_reg.
  - Has priority over a commit on the same edge; that commit is lost and update stays 0.
- Digits not addressed in a commit hold their state indefinitely.

## Timing
- Reset (async assert, any cycle, including mid-run):
  - value=0, digit_valid=0, blank=0, update=0, err=0, cnt=0.
  - s_reg = all ones (seg blank, no anode).
- Deassertion: the first edge after rst falls samples normally.
- Latency: new stable inputs are first captured at edge k. Outputs reflect the commit after edge k+STABLE_CYCLES, i.e. an input held for STABLE_CYCLES+1 edges commits.
- A change at any edge before k+STABLE_CYCLES restarts the window with cnt=0; no partial commit.
- update is registered and high for exactly the cycle following the commit edge.
- With STABLE_CYCLES=1, a value held for 2 edges commits.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Assert rst mid-window (an_n=FE, seg_n=0100100 held 2 cycles) -> all outputs 0 immediately; after release, holding 5 edges commits value[3:0]=2.
- Hold an_n=8'hFE, seg_n=7'b0100100 for 5 edges -> value[3:0]=2, digit_valid=8'h01, update pulses once, no second pulse while held 20 more cycles.
- Hold a pattern 4 edges then change (glitch) -> no commit, update never pulses, value unchanged.
- Scan digits 7..0 with the codes for 1,2,3,4,A,B,C,D, each held 6 edges -> value=32'h1234ABCD, digit_valid=8'hFF, eight update pulses.
- Commit illegal 0111111 on digit 3 -> err=1, digit 3 unchanged. Commit 1111111 on digit 0 -> blank[0]=1, digit_valid[0]=0, value[3:0]=0. Commit an_n=8'hFC -> err stays 1, no update.
- Assert clear on the commit edge of a legal pattern -> all state 0, update stays 0, err cleared.
